// File: rtl/exc_flush_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exc_flush_ctrl_pkg                                                         |
// | Shared state encoding, field widths and exception codes for the flush ctrl |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package exc_flush_ctrl_pkg;

  localparam int ECODE_W_DFLT = 6;
  localparam int ESUB_W_DFLT  = 9;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  localparam logic [ECODE_W_DFLT-1:0] ECODE_INT  = 6'h00;
  localparam logic [ECODE_W_DFLT-1:0] ECODE_ADEF = 6'h08;
  localparam logic [ECODE_W_DFLT-1:0] ECODE_ALE  = 6'h09;
  localparam logic [ECODE_W_DFLT-1:0] ECODE_SYS  = 6'h0B;
  localparam logic [ECODE_W_DFLT-1:0] ECODE_BRK  = 6'h0C;
  localparam logic [ECODE_W_DFLT-1:0] ECODE_INE  = 6'h0D;

endpackage
`default_nettype wire

// File: rtl/exc_flush_ctrl_drain_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exc_drain_cnt                                                              |
// | Loadable 4-bit down-counter with zero flag; holds at zero                  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module exc_drain_cnt (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/exc_flush_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exc_flush_ctrl                                                             |
// | Exception/ertn commit sequencer: CSR strobe, flush, redirect, fetch drain  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module exc_flush_ctrl
  import exc_flush_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int ECODE_W      = 6,
  parameter int ESUB_W       = 9
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wb_valid,
  input  logic               wb_ex,
  input  logic               wb_ertn,
  input  logic [ECODE_W-1:0] wb_ecode,
  input  logic [ESUB_W-1:0]  wb_esubcode,
  input  logic [31:0]        wb_pc,
  input  logic [31:0]        wb_vaddr,
  input  logic [31:0]        csr_eentry,
  input  logic [31:0]        csr_era,
  output logic               csr_ex_we,
  output logic               csr_ertn_we,
  output logic [ECODE_W-1:0] csr_ecode,
  output logic [ESUB_W-1:0]  csr_esubcode,
  output logic [31:0]        csr_era_wdata,
  output logic [31:0]        csr_badv,
  output logic               flush_all,
  output logic               redir_valid,
  input  logic               redir_ready,
  output logic [31:0]        redir_pc,
  output logic               busy
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t             state_q, state_d;
  logic               kind_ex_q, kind_ex_d;
  logic [ECODE_W-1:0] ecode_q, ecode_d;
  logic [ESUB_W-1:0]  esub_q, esub_d;
  logic [31:0]        era_q, era_d;
  logic [31:0]        badv_q, badv_d;
  logic [31:0]        redir_pc_q, redir_pc_d;

  logic       wb_event;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic [3:0] cnt_val;

  assign wb_event = wb_valid & (wb_ex | wb_ertn);

  exc_drain_cnt u_drain_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (DRAIN_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    kind_ex_d  = kind_ex_q;
    ecode_d    = ecode_q;
    esub_d     = esub_q;
    era_d      = era_q;
    badv_d     = badv_q;
    redir_pc_d = redir_pc_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_event) begin
          state_d   = S_COMMIT;
          kind_ex_d = wb_ex;
          ecode_d   = wb_ecode;
          esub_d    = wb_esubcode;
          era_d     = wb_pc;
          badv_d    = wb_vaddr;
        end
      end
      S_COMMIT: begin
        // CSR strobe lands on this edge, so the target is sampled only now.
        state_d    = S_REDIRECT;
        redir_pc_d = kind_ex_q ? csr_eentry : csr_era;
      end
      S_REDIRECT: begin
        if (redir_ready) begin
          state_d  = S_DRAIN;
          cnt_load = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      kind_ex_q  <= 1'b0;
      ecode_q    <= '0;
      esub_q     <= '0;
      era_q      <= 32'd0;
      badv_q     <= 32'd0;
      redir_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      kind_ex_q  <= kind_ex_d;
      ecode_q    <= ecode_d;
      esub_q     <= esub_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign csr_ex_we     = (state_q == S_COMMIT) &  kind_ex_q;
  assign csr_ertn_we   = (state_q == S_COMMIT) & ~kind_ex_q;
  assign csr_ecode     = ecode_q;
  assign csr_esubcode  = esub_q;
  assign csr_era_wdata = era_q;
  assign csr_badv      = badv_q;
  assign flush_all     = (state_q != S_IDLE);
  assign redir_valid   = (state_q == S_REDIRECT);
  assign redir_pc      = redir_pc_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exc_flush_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exc_flush_ctrl                                                          |
// | Directed self-checking bench for exc_flush_ctrl                            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_exc_flush_ctrl;
  import exc_flush_ctrl_pkg::*;

  logic        clk;
  logic        resetn;
  logic        wb_valid, wb_ex, wb_ertn;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, csr_eentry, csr_era;
  logic        csr_ex_we, csr_ertn_we;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic [31:0] csr_era_wdata, csr_badv;
  logic        flush_all, redir_valid, redir_ready;
  logic [31:0] redir_pc;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  exc_flush_ctrl #(.DRAIN_CYCLES(2), .ECODE_W(6), .ESUB_W(9)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wb_valid      (wb_valid),
    .wb_ex         (wb_ex),
    .wb_ertn       (wb_ertn),
    .wb_ecode      (wb_ecode),
    .wb_esubcode   (wb_esubcode),
    .wb_pc         (wb_pc),
    .wb_vaddr      (wb_vaddr),
    .csr_eentry    (csr_eentry),
    .csr_era       (csr_era),
    .csr_ex_we     (csr_ex_we),
    .csr_ertn_we   (csr_ertn_we),
    .csr_ecode     (csr_ecode),
    .csr_esubcode  (csr_esubcode),
    .csr_era_wdata (csr_era_wdata),
    .csr_badv      (csr_badv),
    .flush_all     (flush_all),
    .redir_valid   (redir_valid),
    .redir_ready   (redir_ready),
    .redir_pc      (redir_pc),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle (inputs change just after the rising edge).
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the middle of the current cycle for sampling.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wb_event(input logic ex, input logic ertn, input logic [5:0] ec,
                          input logic [8:0] es, input logic [31:0] pc, input logic [31:0] va);
    wb_valid = 1'b1; wb_ex = ex; wb_ertn = ertn;
    wb_ecode = ec; wb_esubcode = es; wb_pc = pc; wb_vaddr = va;
  endtask

  task automatic wb_clear();
    wb_valid = 1'b0; wb_ex = 1'b0; wb_ertn = 1'b0;
    wb_ecode = '0; wb_esubcode = '0; wb_pc = 32'd0; wb_vaddr = 32'd0;
  endtask

  initial begin
    resetn = 1'b0;
    wb_clear();
    csr_eentry  = 32'h1c008000;
    csr_era     = 32'h1c000204;
    redir_ready = 1'b1;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flush", {31'd0, flush_all}, 32'd0);
    check("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    check("rst_redir_pc", redir_pc, 32'd0);
    check("rst_strobes", {30'd0, csr_ex_we, csr_ertn_we}, 32'd0);
    next_cyc();
    resetn = 1'b1;
    next_cyc();

    // Syscall, ready=1
    wb_event(1'b1, 1'b0, ECODE_SYS, 9'd0, 32'h1c000100, 32'd0);   // T
    mid();
    check("sys_T_busy", {31'd0, busy}, 32'd0);
    next_cyc(); wb_clear();                                       // T+1
    mid();
    check("sys_T1_ex_we", {31'd0, csr_ex_we}, 32'd1);
    check("sys_T1_ertn_we", {31'd0, csr_ertn_we}, 32'd0);
    check("sys_T1_ecode", {26'd0, csr_ecode}, 32'h0B);
    check("sys_T1_era_wdata", csr_era_wdata, 32'h1c000100);
    check("sys_T1_flush", {31'd0, flush_all}, 32'd1);
    check("sys_T1_redir_valid", {31'd0, redir_valid}, 32'd0);
    next_cyc();                                                   // T+2
    mid();
    check("sys_T2_redir_valid", {31'd0, redir_valid}, 32'd1);
    check("sys_T2_redir_pc", redir_pc, 32'h1c008000);
    check("sys_T2_ex_we", {31'd0, csr_ex_we}, 32'd0);
    next_cyc();                                                   // T+3
    mid();
    check("sys_T3_redir_valid", {31'd0, redir_valid}, 32'd0);
    check("sys_T3_flush", {31'd0, flush_all}, 32'd1);
    next_cyc();                                                   // T+4
    mid();
    check("sys_T4_busy", {31'd0, busy}, 32'd1);
    next_cyc();                                                   // T+5
    mid();
    check("sys_T5_busy", {31'd0, busy}, 32'd0);
    check("sys_T5_flush", {31'd0, flush_all}, 32'd0);

    // ertn with IF stalling the redirect for 3 cycles
    next_cyc();
    redir_ready = 1'b0;
    wb_event(1'b0, 1'b1, 6'd0, 9'd0, 32'h1c000400, 32'd0);        // T
    next_cyc(); wb_clear();                                       // T+1
    mid();
    check("ertn_T1_ertn_we", {31'd0, csr_ertn_we}, 32'd1);
    check("ertn_T1_ex_we", {31'd0, csr_ex_we}, 32'd0);
    for (int i = 2; i <= 5; i++) begin                            // T+2..T+5
      next_cyc();
      if (i == 3) csr_era = 32'hdeadbeef;
      if (i == 5) redir_ready = 1'b1;
      mid();
      check($sformatf("ertn_T%0d_redir_valid", i), {31'd0, redir_valid}, 32'd1);
      check($sformatf("ertn_T%0d_redir_pc", i), redir_pc, 32'h1c000204);
      check($sformatf("ertn_T%0d_flush", i), {31'd0, flush_all}, 32'd1);
      check($sformatf("ertn_T%0d_strobes", i), {30'd0, csr_ex_we, csr_ertn_we}, 32'd0);
    end
    csr_era = 32'h1c000204;
    next_cyc(); mid();                                            // T+6
    check("ertn_T6_flush", {31'd0, flush_all}, 32'd1);
    check("ertn_T6_redir_valid", {31'd0, redir_valid}, 32'd0);
    next_cyc(); mid();                                            // T+7
    check("ertn_T7_busy", {31'd0, busy}, 32'd1);
    next_cyc(); mid();                                            // T+8
    check("ertn_T8_busy", {31'd0, busy}, 32'd0);

    // ex and ertn together: exception wins
    next_cyc();
    wb_event(1'b1, 1'b1, ECODE_INE, 9'd0, 32'h1c000500, 32'd0);
    next_cyc(); wb_clear(); mid();
    check("both_T1_ex_we", {31'd0, csr_ex_we}, 32'd1);
    check("both_T1_ertn_we", {31'd0, csr_ertn_we}, 32'd0);
    check("both_T1_ecode", {26'd0, csr_ecode}, 32'h0D);
    next_cyc(); mid();
    check("both_T2_redir_pc", redir_pc, 32'h1c008000);
    for (int i = 0; i < 3; i++) next_cyc();                       // T+5
    mid();
    check("both_T5_busy", {31'd0, busy}, 32'd0);

    // Second event during DRAIN is ignored
    next_cyc();
    wb_event(1'b1, 1'b0, ECODE_SYS, 9'd0, 32'h1c000600, 32'd0);
    next_cyc(); wb_clear();                                       // T+1
    next_cyc();                                                   // T+2
    next_cyc();                                                   // T+3 (DRAIN)
    wb_event(1'b1, 1'b0, ECODE_BRK, 9'd5, 32'h1c000700, 32'h44);
    mid();
    check("drain_T3_strobes", {30'd0, csr_ex_we, csr_ertn_we}, 32'd0);
    next_cyc(); wb_clear(); mid();                                // T+4
    check("drain_T4_strobes", {30'd0, csr_ex_we, csr_ertn_we}, 32'd0);
    check("drain_T4_busy", {31'd0, busy}, 32'd1);
    next_cyc(); mid();                                            // T+5
    check("drain_T5_busy", {31'd0, busy}, 32'd0);
    check("drain_T5_ecode", {26'd0, csr_ecode}, 32'h0B);
    check("drain_T5_era_wdata", csr_era_wdata, 32'h1c000600);
    next_cyc(); mid();
    check("drain_T6_strobes", {30'd0, csr_ex_we, csr_ertn_we}, 32'd0);

    // Reset pulsed while in REDIRECT
    redir_ready = 1'b0;
    wb_event(1'b1, 1'b0, ECODE_BRK, 9'd0, 32'h1c000800, 32'd0);
    next_cyc(); wb_clear();
    next_cyc(); mid();                                            // T+2
    check("rstmid_T2_redir_valid", {31'd0, redir_valid}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("rstmid_redir_valid", {31'd0, redir_valid}, 32'd0);
    check("rstmid_flush", {31'd0, flush_all}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_ecode", {26'd0, csr_ecode}, 32'd0);
    check("rstmid_redir_pc", redir_pc, 32'd0);
    next_cyc();
    resetn = 1'b1;
    redir_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cyc(); mid();
      check($sformatf("rstmid_idle%0d_strobes", i), {29'd0, csr_ex_we, csr_ertn_we, redir_valid}, 32'd0);
    end

    // ALE restart after reset
    next_cyc();
    wb_event(1'b1, 1'b0, ECODE_ALE, 9'd0, 32'h1c000300, 32'h00000003);
    next_cyc(); wb_clear(); mid();
    check("ale_T1_ex_we", {31'd0, csr_ex_we}, 32'd1);
    check("ale_T1_badv", csr_badv, 32'h00000003);
    check("ale_T1_ecode", {26'd0, csr_ecode}, 32'h09);
    check("ale_T1_era_wdata", csr_era_wdata, 32'h1c000300);
    next_cyc(); mid();
    check("ale_T2_redir_pc", redir_pc, 32'h1c008000);
    for (int i = 0; i < 3; i++) next_cyc();
    mid();
    check("ale_T5_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
